// File: rtl/seg_mmio_pkg.sv
// Shared register map for the seven-segment MMIO responder: offsets, CTRL/STATUS
// bit positions and reset values, reused by software-visible tests.
package seg_mmio_pkg;

  localparam logic [1:0] OFS_VALUE  = 2'd0;
  localparam logic [1:0] OFS_CTRL   = 2'd1;
  localparam logic [1:0] OFS_STATUS = 2'd2;

  localparam int CTRL_EN_LSB    = 0;
  localparam int CTRL_DP_LSB    = 8;
  localparam int CTRL_BLANK_BIT = 16;

  localparam logic [31:0] CTRL_RESET = 32'h0000_00FF;
  localparam logic [31:0] CTRL_MASK  = 32'h0001_FFFF;

  localparam int STAT_PEND_BIT  = 3;
  localparam int STAT_FRAME_LSB = 8;

  function automatic logic [31:0] status_word(input logic [2:0] idx,
                                              input logic       pend,
                                              input logic [7:0] frame);
    return {16'h0000, frame, 4'h0, pend, idx};
  endfunction

endpackage

// File: rtl/seg_mmio_hex7seg.sv
// Nibble to seven-segment pattern, bit order {g,f,e,d,c,b,a}, active-high.
module hex7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] pat_o
);

  always_comb begin
    pat_o = 7'h00;
    case (nib_i)
      4'h0: pat_o = 7'h3F;
      4'h1: pat_o = 7'h06;
      4'h2: pat_o = 7'h5B;
      4'h3: pat_o = 7'h4F;
      4'h4: pat_o = 7'h66;
      4'h5: pat_o = 7'h6D;
      4'h6: pat_o = 7'h7D;
      4'h7: pat_o = 7'h07;
      4'h8: pat_o = 7'h7F;
      4'h9: pat_o = 7'h6F;
      4'hA: pat_o = 7'h77;
      4'hB: pat_o = 7'h7C;
      4'hC: pat_o = 7'h39;
      4'hD: pat_o = 7'h5E;
      4'hE: pat_o = 7'h79;
      4'hF: pat_o = 7'h71;
      default: pat_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_mmio.sv
// Memory-mapped 8-digit seven-segment responder. VALUE writes are double-buffered
// and only reach the display at a scan-frame boundary.
module seg_mmio
  import seg_mmio_pkg::*;
#(
  parameter logic [7:0]  BASE = 8'hF0,
  parameter int unsigned DIV  = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  ad,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic        rden,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [63:0] seg_out,
  output logic [7:0]  seg_sel
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    frame_q, frame_d;
  logic [31:0]   pending_q, pending_d;
  logic [31:0]   shown_q, shown_d;
  logic          pend_q, pend_d;
  logic [31:0]   ctrl_q, ctrl_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [63:0]   seg_out_q, seg_out_d;
  logic [7:0]    seg_sel_q, seg_sel_d;

  logic [7:0]    offs;
  logic          in_win;
  logic          tick;
  logic          boundary;
  logic [31:0]   rd_mux;
  logic [6:0]    pat [8];

  // Modular difference keeps the window test correct for any BASE.
  assign offs     = ad - BASE;
  assign in_win   = (offs < 8'd3);
  assign hit      = in_win & (wren | rden);
  assign tick     = (cnt_q == CW'(DIV - 1));
  assign boundary = tick & (idx_q == 3'd7);

  always_comb begin
    rd_mux = 32'h0;
    case (offs[1:0])
      OFS_VALUE:  rd_mux = pending_q;
      OFS_CTRL:   rd_mux = ctrl_q;
      OFS_STATUS: rd_mux = status_word(idx_q, pend_q, frame_q);
      default:    rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    frame_d   = boundary ? frame_q + 8'd1 : frame_q;
    pending_d = pending_q;
    shown_d   = shown_q;
    pend_d    = pend_q;
    ctrl_d    = ctrl_q;
    rdata_d   = rdata_q;
    if (boundary && pend_q) begin
      shown_d = pending_q;
      pend_d  = 1'b0;
    end
    // A store in the boundary cycle re-arms the flag after the commit above.
    if (wren && in_win) begin
      case (offs[1:0])
        OFS_VALUE: begin
          pending_d = wdata;
          pend_d    = 1'b1;
        end
        OFS_CTRL: ctrl_d = wdata & CTRL_MASK;
        default:  ;
      endcase
    end
    if (rden && in_win) rdata_d = rd_mux;
  end

  for (genvar g = 0; g < 8; g++) begin : g_dig
    hex7seg u_hex (
      .nib_i (shown_q[4*g +: 4]),
      .pat_o (pat[g])
    );
  end

  always_comb begin
    seg_out_d = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (ctrl_q[CTRL_EN_LSB + i] && !ctrl_q[CTRL_BLANK_BIT])
        seg_out_d[8*i +: 8] = {ctrl_q[CTRL_DP_LSB + i], pat[i]};
    end
    seg_sel_d = ctrl_q[CTRL_BLANK_BIT] ? 8'h00
                                       : ((8'h01 << idx_q) & ctrl_q[CTRL_EN_LSB +: 8]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      frame_q   <= 8'd0;
      pending_q <= 32'h0;
      shown_q   <= 32'h0;
      pend_q    <= 1'b0;
      ctrl_q    <= CTRL_RESET;
      rdata_q   <= 32'h0;
      seg_out_q <= 64'h3F3F_3F3F_3F3F_3F3F;
      seg_sel_q <= 8'h01;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      pend_q    <= pend_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      seg_out_q <= seg_out_d;
      seg_sel_q <= seg_sel_d;
    end
  end

  assign rdata   = rdata_q;
  assign seg_out = seg_out_q;
  assign seg_sel = seg_sel_q;

endmodule

// File: tb/tb_seg_mmio.sv
// Directed bench for seg_mmio with DIV=4: register access, scan stepping,
// frame-boundary commit, blanking/enables and mid-frame reset.
module tb_seg_mmio;

  localparam logic [7:0] BASE = 8'hF0;
  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  ad = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic [63:0] seg_out;
  logic [7:0]  seg_sel;

  int total = 0;
  int bad = 0;
  int ncyc = 0;

  seg_mmio #(.BASE(BASE), .DIV(DIV)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .ad      (ad),
    .wdata   (wdata),
    .wren    (wren),
    .rden    (rden),
    .hit     (hit),
    .rdata   (rdata),
    .seg_out (seg_out),
    .seg_sel (seg_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic wait_until(input int n);
    while (ncyc < n) step();
  endtask

  task automatic store(input logic [1:0] off, input logic [31:0] d);
    ad = BASE + 8'(off);
    wdata = d;
    wren = 1'b1;
    step();
    wren = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] off, input logic [31:0] exp);
    ad = BASE + 8'(off);
    rden = 1'b1;
    #1;
    chk({tag, "_hit"}, 64'(hit), 64'd1);
    step();
    rden = 1'b0;
    chk(tag, 64'(rdata), 64'(exp));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg_out", seg_out, 64'h3F3F_3F3F_3F3F_3F3F);
    chk("rst_seg_sel", 64'(seg_sel), 64'h01);
    chk("rst_rdata", 64'(rdata), 64'h0);
    n_rst = 1'b1;
    ncyc = 0;

    load("rst_status", 2'd2, 32'h0);

    // VALUE store is held until the frame boundary
    store(2'd0, 32'h0123_ABCD);
    load("pend_status", 2'd2, 32'h0000_0008);
    wait_until(31);
    chk("pre_commit_seg", seg_out, 64'h3F3F_3F3F_3F3F_3F3F);
    wait_until(33);
    chk("commit_seg", seg_out, 64'h3F06_5B4F_777C_395E);
    load("frame1_status", 2'd2, 32'h0000_0100);
    load("value_rd", 2'd0, 32'h0123_ABCD);

    // Scan index stepping, sampled mid-step
    for (int k = 0; k < 9; k++) begin
      wait_until(38 + 4 * k);
      chk("scan_sel", 64'(seg_sel), 64'(8'h01 << (((38 + 4 * k) / 4) % 8)));
    end

    // Blank, then partial enables with decimal points
    store(2'd1, 32'h0001_0000);
    step();
    chk("blank_seg", seg_out, 64'h0);
    chk("blank_sel", 64'(seg_sel), 64'h0);
    store(2'd1, 32'h0000_0F05);
    step();
    chk("en_seg", seg_out, 64'h0000_0000_00FC_00DE);
    load("ctrl_rd", 2'd1, 32'h0000_0F05);
    for (int k = 0; k < 32; k++) begin
      step();
      chk("en_sel_mask", 64'(seg_sel & 8'hFA), 64'h0);
    end
    store(2'd1, 32'h0000_00FF);

    // Store coinciding with a frame boundary
    store(2'd0, 32'h1111_1111);
    wait_until(127);
    store(2'd0, 32'h0000_0005);
    store(2'd0, 32'h0000_0006);
    step();
    chk("bnd_old_seg", seg_out, 64'h0606_0606_0606_0606);
    load("bnd_status", 2'd2, 32'h0000_0408);

    // Out-of-window load
    ad = BASE + 8'd3;
    rden = 1'b1;
    #1;
    chk("oow_hit", 64'(hit), 64'd0);
    step();
    rden = 1'b0;
    chk("oow_rdata", 64'(rdata), 64'h0000_0408);

    wait_until(159);
    chk("bnd_hold_seg", seg_out, 64'h0606_0606_0606_0606);
    wait_until(161);
    chk("bnd_new_seg", seg_out, 64'h3F3F_3F3F_3F3F_3F7D);

    // Simultaneous store and load: load sees the pre-store value
    ad = BASE;
    wdata = 32'h0000_0007;
    wren = 1'b1;
    rden = 1'b1;
    step();
    wren = 1'b0;
    rden = 1'b0;
    chk("rw_rdata", 64'(rdata), 64'h6);
    load("rw_after", 2'd0, 32'h0000_0007);

    // Mid-frame reset with a pending value
    store(2'd0, 32'h0000_0009);
    wait_until(170);
    load("pre_rst_status", 2'd2, 32'h0000_050A);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_seg", seg_out, 64'h3F3F_3F3F_3F3F_3F3F);
    chk("mid_rst_sel", 64'(seg_sel), 64'h01);
    chk("mid_rst_rdata", 64'(rdata), 64'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    ncyc = 0;
    load("post_rst_status", 2'd2, 32'h0);
    wait_until(33);
    chk("post_rst_seg", seg_out, 64'h3F3F_3F3F_3F3F_3F3F);
    load("post_rst_value", 2'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
